ram_write_arbiter: RTL and testbench

//  Shares the single internal-RAM write port (ram_wr_en_data/ram_wr_addr/ram_wr_byte) between
//  CPU data writes, stack pushes and peripheral SFR updates (timer flags, port sampling).

---
 rtl/ram_arb_pkg.sv | 21 ++
 rtl/ram_write_arbiter_if.sv | 17 +
 rtl/rr_pick.sv | 30 +++
 rtl/ram_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_ram_write_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared constants, state encoding and helpers for the RAM write arbiter
package ram_arb_pkg;

   localparam int REQ_CPU   = 0;
   localparam int REQ_STACK = 1;
   localparam int REQ_SFR   = 2;
   localparam int N_REQ     = 3;

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } arb_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/ram_write_arbiter_if.sv
// rtl/ram_write_arbiter_if.sv - requester-side request/grant bus of the RAM write arbiter
interface ram_write_arbiter_if #(
   parameter int N      = 3,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);

   logic [N-1:0]        req;
   logic [N-1:0]        lock;
   logic [N*ADDR_W-1:0] req_addr;
   logic [N*DATA_W-1:0] req_data;
   logic [N-1:0]        gnt;

   modport master (output req, output lock, output req_addr, output req_data, input gnt);
   modport slave  (input req, input lock, input req_addr, input req_data, output gnt);

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - N-wide round-robin picker, first requester at or after ptr wins
module rr_pick
   import ram_arb_pkg::*;
#(
   parameter int N = 2,
   localparam int PW = (N > 1) ? clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   logic [PW-1:0] idx;
   logic          found;

   // scan from ptr upward with wrap, grant the first active request
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int off = 0; off < N; off++) begin
         idx = PW'((int'(ptr) + off) % N);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_write_arbiter.sv
// rtl/ram_write_arbiter.sv - shares the internal RAM write port between CPU, stack and SFR updates
module ram_write_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 4,
   parameter int LOCK_MAX = 8
) (
   input  logic              clock,
   input  logic              reset,
   ram_write_arbiter_if.slave bus,
   output logic              ram_wr_en_data,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [DATA_W-1:0] ram_wr_byte,
   output logic [1:0]        owner,
   output logic              locked,
   output logic              lock_err
);

   localparam int WAIT_W = clog2(MAX_WAIT + 1);
   localparam int LCNT_W = clog2(LOCK_MAX + 1);
   localparam logic [1:0] IDX_CPU   = 2'(REQ_CPU);
   localparam logic [1:0] IDX_STACK = 2'(REQ_STACK);
   localparam logic [1:0] IDX_SFR   = 2'(REQ_SFR);

   arb_state_t        state, state_nx;
   logic [WAIT_W-1:0] wait_cnt [N_REQ];
   logic [LCNT_W-1:0] lock_cnt;
   logic [1:0]        rr_ptr;
   logic [N_REQ-1:0]  promo_gnt;
   logic [N_REQ-1:0]  gnt_c;
   logic [1:0]        rr_gnt;
   logic [1:0]        gnt_idx;
   logic              gnt_any;
   logic              force_rel;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   // round-robin among the non-CPU requesters; pointer 1 = stack first, 2 = SFR first
   rr_pick #(.N(N_REQ - 1)) u_rr (
      .req (bus.req[N_REQ-1:1]),
      .ptr (rr_ptr == IDX_SFR),
      .gnt (rr_gnt)
   );

   // lowest-index requester whose wait counter has saturated gets promoted
   always_comb begin
      promo_gnt = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (promo_gnt == '0 && bus.req[i] && wait_cnt[i] == WAIT_W'(MAX_WAIT))
            promo_gnt[i] = 1'b1;
      end
   end

   // grant selection and lock FSM next state; forced release grants nothing that cycle
   always_comb begin
      gnt_c     = '0;
      state_nx  = state;
      force_rel = 1'b0;
      unique case (state)
         ST_UNLOCKED: begin
            if (promo_gnt != '0)          gnt_c = promo_gnt;
            else if (bus.req[REQ_CPU])    gnt_c[REQ_CPU] = 1'b1;
            else                          gnt_c = {rr_gnt, 1'b0};
            if ((gnt_c & bus.lock) != '0) state_nx = ST_LOCKED;
         end
         ST_LOCKED: begin
            if (lock_cnt == LCNT_W'(LOCK_MAX - 1)) begin
               force_rel = 1'b1;
               state_nx  = ST_UNLOCKED;
            end else begin
               gnt_c[owner] = bus.req[owner];
               if (!bus.lock[owner]) state_nx = ST_UNLOCKED;
            end
         end
         default: ;
      endcase
      if (!reset) gnt_c = '0;
   end

   assign bus.gnt = gnt_c;
   assign gnt_any = |gnt_c;
   assign locked  = (state == ST_LOCKED);

   // encode the granted index and route its address/data toward the output register
   always_comb begin
      gnt_idx  = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_c[i]) begin
            gnt_idx  = 2'(i);
            sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            sel_data = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // lock FSM state, lock duration counter and forced-release error pulse
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= ST_UNLOCKED;
         lock_cnt <= '0;
         lock_err <= 1'b0;
      end else begin
         state    <= state_nx;
         lock_err <= force_rel;
         if (state == ST_UNLOCKED) lock_cnt <= '0;
         else                      lock_cnt <= lock_cnt + 1'b1;
      end
   end

   // per-requester wait counters: count unserved cycles, saturate, clear on grant or drop
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_REQ; i++) wait_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!bus.req[i] || gnt_c[i])             wait_cnt[i] <= '0;
            else if (wait_cnt[i] != WAIT_W'(MAX_WAIT)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
         end
      end
   end

   // registered RAM write port, owner tracking and round-robin pointer advance
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ram_wr_en_data <= 1'b0;
         ram_wr_addr    <= '0;
         ram_wr_byte    <= '0;
         owner          <= IDX_CPU;
         rr_ptr         <= IDX_STACK;
      end else begin
         ram_wr_en_data <= gnt_any;
         if (gnt_any) begin
            ram_wr_addr <= sel_addr;
            ram_wr_byte <= sel_data;
            owner       <= gnt_idx;
            if (gnt_idx != IDX_CPU)
               rr_ptr <= (gnt_idx == IDX_SFR) ? IDX_STACK : gnt_idx + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_ram_write_arbiter.sv
// tb/tb_ram_write_arbiter.sv - randomized self-checking bench for ram_write_arbiter
module tb_ram_write_arbiter;
   import ram_arb_pkg::*;

   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 8;
   localparam int MAX_WAIT = 4;
   localparam int LOCK_MAX = 8;

   logic              clock = 1'b0;
   logic              reset;
   logic              ram_wr_en_data;
   logic [ADDR_W-1:0] ram_wr_addr;
   logic [DATA_W-1:0] ram_wr_byte;
   logic [1:0]        owner;
   logic              locked;
   logic              lock_err;

   ram_write_arbiter_if #(.N(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ram_write_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .bus            (bus),
      .ram_wr_en_data (ram_wr_en_data),
      .ram_wr_addr    (ram_wr_addr),
      .ram_wr_byte    (ram_wr_byte),
      .owner          (owner),
      .locked         (locked),
      .lock_err       (lock_err)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   bit          r_req  [N_REQ];
   bit          r_lock [N_REQ];
   logic [7:0]  r_addr [N_REQ];
   logic [7:0]  r_data [N_REQ];

   int          m_wait [N_REQ];
   int          m_rr;
   int          m_owner;
   bit          m_locked;
   int          m_lock_cycles;
   bit          e_en;
   logic [7:0]  e_addr;
   logic [7:0]  e_byte;
   bit          e_lock_err;
   int          g;
   bit          forced;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < N_REQ; i++) begin
         bus.req[i]                 = r_req[i];
         bus.lock[i]                = r_lock[i];
         bus.req_addr[i*ADDR_W +: ADDR_W] = r_addr[i];
         bus.req_data[i*DATA_W +: DATA_W] = r_data[i];
      end
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N_REQ; i++) begin
         r_req[i]  = 1'b0;
         r_lock[i] = 1'b0;
         r_addr[i] = 8'h00;
         r_data[i] = 8'h00;
      end
   endtask

   task automatic set_req(input int i, input bit rq, input bit lk, input logic [7:0] a, input logic [7:0] d);
      r_req[i]  = rq;
      r_lock[i] = lk;
      r_addr[i] = a;
      r_data[i] = d;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_REQ; i++) m_wait[i] = 0;
      m_rr = 1; m_owner = 0; m_locked = 1'b0; m_lock_cycles = 0;
      e_en = 1'b0; e_addr = 8'h00; e_byte = 8'h00; e_lock_err = 1'b0;
   endtask

   // who should win this cycle, from the arbitration rules
   task automatic model_pick();
      g = -1;
      forced = 1'b0;
      if (!m_locked) begin
         for (int i = 0; i < N_REQ; i++)
            if (g < 0 && r_req[i] && m_wait[i] == MAX_WAIT) g = i;
         if (g < 0 && r_req[0]) g = 0;
         for (int k = 0; k < 2; k++) begin
            int j;
            j = ((m_rr - 1 + k) % 2) + 1;
            if (g < 0 && r_req[j]) g = j;
         end
      end else if (m_lock_cycles == LOCK_MAX - 1) begin
         forced = 1'b1;
      end else if (r_req[m_owner]) begin
         g = m_owner;
      end
   endtask

   task automatic model_commit();
      e_lock_err = forced;
      e_en = (g >= 0);
      if (g >= 0) begin
         e_addr  = r_addr[g];
         e_byte  = r_data[g];
         m_owner = g;
         if (g > 0) m_rr = (g == 2) ? 1 : g + 1;
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!r_req[i] || i == g)     m_wait[i] = 0;
         else if (m_wait[i] < MAX_WAIT) m_wait[i] = m_wait[i] + 1;
      end
      if (!m_locked) begin
         if (g >= 0 && r_lock[g]) begin
            m_locked = 1'b1;
            m_lock_cycles = 0;
         end
      end else if (forced) begin
         m_locked = 1'b0;
      end else begin
         m_lock_cycles++;
         if (!r_lock[m_owner]) m_locked = 1'b0;
      end
   endtask

   task automatic step();
      @(negedge clock);
      model_pick();
      check("gnt",      {29'd0, bus.gnt},        (g >= 0) ? (32'd1 << g) : 32'd0);
      check("wr_en",    {31'd0, ram_wr_en_data}, {31'd0, e_en});
      check("wr_addr",  {24'd0, ram_wr_addr},    {24'd0, e_addr});
      check("wr_byte",  {24'd0, ram_wr_byte},    {24'd0, e_byte});
      check("owner",    {30'd0, owner},          32'(m_owner));
      check("locked",   {31'd0, locked},         {31'd0, m_locked});
      check("lock_err", {31'd0, lock_err},       {31'd0, e_lock_err});
      @(posedge clock);
      model_commit();
      #1;
   endtask

   task automatic rand_next();
      for (int i = 0; i < N_REQ; i++) begin
         bit was;
         was = r_req[i];
         if (r_req[i] && g == i)  r_req[i] = ($urandom % 4 == 0);
         else if (r_req[i])       r_req[i] = ($urandom % 16 != 0);
         else                     r_req[i] = ($urandom % 3 == 0);
         if (r_req[i] && (!was || g == i)) begin
            r_addr[i] = 8'($urandom);
            r_data[i] = 8'($urandom);
         end
         if (m_locked && i == m_owner) r_lock[i] = ($urandom % 8 != 0);
         else                          r_lock[i] = ($urandom % 5 == 0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      clear_reqs();
      set_req(0, 1'b1, 1'b0, 8'h12, 8'h34);
      apply();
      model_reset();
      #12;
      check("rst_gnt",      {29'd0, bus.gnt},        32'd0);
      check("rst_en",       {31'd0, ram_wr_en_data}, 32'd0);
      check("rst_addr",     {24'd0, ram_wr_addr},    32'd0);
      check("rst_byte",     {24'd0, ram_wr_byte},    32'd0);
      check("rst_owner",    {30'd0, owner},          32'd0);
      check("rst_locked",   {31'd0, locked},         32'd0);
      check("rst_lock_err", {31'd0, lock_err},       32'd0);
      clear_reqs();
      apply();
      @(posedge clock); #1;
      reset = 1'b1;

      // single write
      set_req(0, 1'b1, 1'b0, 8'h30, 8'hA5); apply(); step();
      check("single_en", {31'd0, ram_wr_en_data}, 32'd1);
      clear_reqs(); apply(); step();

      // reset asserted while a write is on the port
      set_req(0, 1'b1, 1'b0, 8'h44, 8'h11); apply(); step();
      check("midw_en_before", {31'd0, ram_wr_en_data}, 32'd1);
      reset = 1'b0;
      #1;
      check("midw_en_async",  {31'd0, ram_wr_en_data}, 32'd0);
      check("midw_addr",      {24'd0, ram_wr_addr},    32'd0);
      clear_reqs(); apply(); model_reset();
      @(posedge clock); #1;
      reset = 1'b1;
      step();

      // contention: stack first after reset, then alternation
      for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 1'b0, 8'h50 + 8'(i), 8'hC0 + 8'(i));
      apply();
      repeat (2) step();
      r_req[0] = 1'b0; apply();
      repeat (4) step();
      clear_reqs(); apply(); step();

      // starvation: CPU every cycle, stack promoted after MAX_WAIT
      set_req(0, 1'b1, 1'b0, 8'h01, 8'h10);
      set_req(1, 1'b1, 1'b0, 8'h02, 8'h20);
      apply();
      repeat (6) step();
      clear_reqs(); apply(); step();

      // lock: SFR read-modify-write, CPU blocked until release
      set_req(2, 1'b1, 1'b1, 8'h89, 8'h5A); apply(); step();
      r_req[2] = 1'b0; set_req(0, 1'b1, 1'b0, 8'h07, 8'h77); apply();
      repeat (2) step();
      r_lock[2] = 1'b0; apply(); step();
      step();
      clear_reqs(); apply(); step();

      // lock timeout: forced release, then CPU served
      set_req(2, 1'b1, 1'b1, 8'h90, 8'h99); apply(); step();
      set_req(0, 1'b1, 1'b0, 8'h08, 8'h88); apply();
      repeat (11) step();
      clear_reqs(); apply(); step();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         rand_next();
         apply();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
